// File: rtl/ram_stream_reader_pkg.sv
// Shared definitions for the RAM stream reader: controller states and FIFO sizing.
package ram_stream_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned FIFO_PTR_W = $clog2(FIFO_DEPTH);

endpackage

// File: rtl/rd_fifo.sv
// Depth-4 synchronous FIFO holding RAM read data; head is presented from storage
// directly so a word is visible the cycle after it is pushed.
module rd_fifo
  import ram_stream_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  empty,
  output logic [FIFO_PTR_W:0]   count
);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [FIFO_PTR_W-1:0] wr_ptr;
  logic [FIFO_PTR_W-1:0] rd_ptr;
  logic                  full;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (FIFO_PTR_W+1)'(FIFO_DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push at full is still accepted.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + FIFO_PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + FIFO_PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (FIFO_PTR_W+1)'(1);
        2'b01:   count <= count - (FIFO_PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ram_stream_reader.sv
// Reads LEN consecutive words from an external registered-output RAM starting at
// BASE and streams them out over a VALID/READY interface, with credit-based
// read issue so the 4-entry output FIFO can never overflow.
module ram_stream_reader
  import ram_stream_reader_pkg::*;
#(
  parameter int unsigned BUS_WIDTH  = 7,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  START,
  input  logic [BUS_WIDTH-1:0]  BASE,
  input  logic [BUS_WIDTH:0]    LEN,
  output logic [BUS_WIDTH-1:0]  ADDR_R,
  input  logic [DATA_WIDTH-1:0] RAM_DOUT,
  output logic [DATA_WIDTH-1:0] DOUT,
  output logic                  VALID,
  input  logic                  READY,
  output logic                  BUSY,
  output logic                  DONE
);

  state_t                state;
  logic [BUS_WIDTH-1:0]  addr_cnt;
  logic [BUS_WIDTH:0]    issue_rem;
  logic [BUS_WIDTH:0]    out_rem;
  // [0]: address is on ADDR_R this cycle, [1]: its data is on RAM_DOUT this cycle.
  logic [1:0]            inflight;
  logic [FIFO_PTR_W:0]   occ;
  logic [FIFO_PTR_W+1:0] pending;
  logic                  fifo_empty;
  logic                  issue;
  logic                  xfer;
  logic                  last_xfer;

  assign VALID = !fifo_empty;

  // Issue credit check and stream handshake decode.
  always_comb begin
    pending   = {1'b0, occ} + (FIFO_PTR_W+2)'(inflight[0]) + (FIFO_PTR_W+2)'(inflight[1]);
    issue     = (state == RUN) && (issue_rem != '0) &&
                (pending < (FIFO_PTR_W+2)'(FIFO_DEPTH));
    xfer      = VALID && READY;
    last_xfer = xfer && (out_rem == (BUS_WIDTH+1)'(1));
  end

  // Controller FSM with registered address, in-flight pipeline and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr_cnt  <= '0;
      issue_rem <= '0;
      out_rem   <= '0;
      inflight  <= '0;
      ADDR_R    <= '0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
    end else begin
      DONE     <= 1'b0;
      inflight <= {inflight[0], issue};
      if (issue) begin
        ADDR_R    <= addr_cnt;
        addr_cnt  <= addr_cnt + BUS_WIDTH'(1);
        issue_rem <= issue_rem - (BUS_WIDTH+1)'(1);
      end
      if (xfer && (out_rem != '0)) begin
        out_rem <= out_rem - (BUS_WIDTH+1)'(1);
      end
      case (state)
        IDLE: begin
          // BUSY is left set through the DONE cycle and cleared on the next edge.
          BUSY <= 1'b0;
          if (START) begin
            if (LEN == '0) begin
              DONE <= 1'b1;
            end else begin
              state     <= RUN;
              addr_cnt  <= BASE;
              issue_rem <= LEN;
              out_rem   <= LEN;
              BUSY      <= 1'b1;
            end
          end
        end
        RUN: begin
          if (issue && (issue_rem == (BUS_WIDTH+1)'(1))) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (last_xfer) begin
            state <= IDLE;
            DONE  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  rd_fifo #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (inflight[1]),
    .push_data(RAM_DOUT),
    .pop      (xfer),
    .head     (DOUT),
    .empty    (fifo_empty),
    .count    (occ)
  );

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed testbench for ram_stream_reader with a registered-read RAM model (RAM[a]=a).
module tb_ram_stream_reader;

  localparam int unsigned BW = 7;
  localparam int unsigned DW = 8;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          START = 1'b0;
  logic          READY = 1'b0;
  logic [BW-1:0] BASE  = '0;
  logic [BW:0]   LEN   = '0;
  logic [BW-1:0] ADDR_R;
  logic [DW-1:0] RAM_DOUT;
  logic [DW-1:0] DOUT;
  logic          VALID;
  logic          BUSY;
  logic          DONE;

  int unsigned   n_checks = 0;
  int unsigned   n_fail   = 0;
  logic [BW-1:0] addr_log [4];

  ram_stream_reader #(
    .BUS_WIDTH (BW),
    .DATA_WIDTH(DW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .START   (START),
    .BASE    (BASE),
    .LEN     (LEN),
    .ADDR_R  (ADDR_R),
    .RAM_DOUT(RAM_DOUT),
    .DOUT    (DOUT),
    .VALID   (VALID),
    .READY   (READY),
    .BUSY    (BUSY),
    .DONE    (DONE)
  );

  always #5 clk = ~clk;

  // External RAM: registered read port, contents equal to address.
  always @(posedge clk) RAM_DOUT <= DW'(ADDR_R);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic start_cmd(input logic [BW-1:0] b, input logic [BW:0] l);
    @(negedge clk);
    START = 1'b1;
    BASE  = b;
    LEN   = l;
  endtask

  // mode 0: READY=1, mode 1: READY toggles, mode 2: READY=0 for 20 cycles then 1.
  // inject: pulse START (BASE=0, LEN=2) while the command is running.
  task automatic run_stream(input logic [BW-1:0] b, input int unsigned len,
                            input int unsigned mode, input bit inject, input string tag);
    int unsigned   idx = 0;
    int unsigned   cyc = 0;
    int unsigned   max_occ = 0;
    int unsigned   budget = len * 4 + 40;
    logic [DW-1:0] held = '0;
    logic          held_v = 1'b0;
    logic [BW-1:0] a;
    while (idx < len && cyc < budget) begin
      @(negedge clk);
      START = 1'b0;
      if (inject && cyc == 1) begin
        START = 1'b1;
        BASE  = '0;
        LEN   = (BW+1)'(2);
      end
      if (held_v) begin
        check_eq({tag, "_stall_valid"}, 32'(VALID), 32'd1);
        check_eq({tag, "_stall_dout"}, 32'(DOUT), 32'(held));
      end
      case (mode)
        0:       READY = 1'b1;
        1:       READY = cyc[0];
        default: READY = (cyc >= 20);
      endcase
      if (32'(dut.u_fifo.count) > max_occ) max_occ = 32'(dut.u_fifo.count);
      if (mode == 2 && cyc == 19) begin
        check_eq({tag, "_stall_addr"}, 32'(ADDR_R), 32'(BW'(b + BW'(3))));
        check_eq({tag, "_stall_occ"}, 32'(dut.u_fifo.count), 32'd4);
        check_eq({tag, "_stall_head"}, 32'(DOUT), 32'(b));
      end
      if (cyc >= 1 && cyc <= 4) addr_log[cyc-1] = ADDR_R;
      if (VALID && READY) begin
        a = b + BW'(idx);
        check_eq({tag, "_word"}, 32'(DOUT), 32'(a));
        idx++;
        held_v = 1'b0;
      end else if (VALID) begin
        held   = DOUT;
        held_v = 1'b1;
      end else begin
        held_v = 1'b0;
      end
      cyc++;
    end
    START = 1'b0;
    check_eq({tag, "_occ_le_4"}, 32'(max_occ <= 4), 32'd1);
    if (idx < len) begin
      check_eq({tag, "_timeout_words"}, idx, len);
    end else begin
      @(negedge clk);
      check_eq({tag, "_done_pulse"}, 32'(DONE), 32'd1);
      check_eq({tag, "_busy_in_done"}, 32'(BUSY), 32'd1);
      check_eq({tag, "_valid_after"}, 32'(VALID), 32'd0);
      @(negedge clk);
      check_eq({tag, "_done_clear"}, 32'(DONE), 32'd0);
      check_eq({tag, "_busy_clear"}, 32'(BUSY), 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_addr", 32'(ADDR_R), 32'd0);
    check_eq("rst_valid", 32'(VALID), 32'd0);
    check_eq("rst_dout", 32'(DOUT), 32'd0);
    check_eq("rst_busy", 32'(BUSY), 32'd0);
    check_eq("rst_done", 32'(DONE), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // BASE=0x10 LEN=4 READY=1: latency and back-to-back words
    READY = 1'b1;
    start_cmd(7'h10, 8'd4);
    @(negedge clk);
    START = 1'b0;
    check_eq("t1_busy", 32'(BUSY), 32'd1);
    check_eq("t1_valid_n1", 32'(VALID), 32'd0);
    @(negedge clk);
    check_eq("t1_addr_first", 32'(ADDR_R), 32'h10);
    check_eq("t1_valid_n2", 32'(VALID), 32'd0);
    @(negedge clk);
    check_eq("t1_valid_n3", 32'(VALID), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("t1_valid", 32'(VALID), 32'd1);
      check_eq("t1_dout", 32'(DOUT), 32'h10 + 32'(i));
      check_eq("t1_done_early", 32'(DONE), 32'd0);
      if (i == 2) check_eq("t1_addr_hold", 32'(ADDR_R), 32'h13);
    end
    @(negedge clk);
    check_eq("t1_done", 32'(DONE), 32'd1);
    check_eq("t1_busy_done", 32'(BUSY), 32'd1);
    check_eq("t1_valid_end", 32'(VALID), 32'd0);
    @(negedge clk);
    check_eq("t1_done_clr", 32'(DONE), 32'd0);
    check_eq("t1_busy_clr", 32'(BUSY), 32'd0);

    // Address wrap: BASE=0x7E LEN=4
    start_cmd(7'h7E, 8'd4);
    run_stream(7'h7E, 4, 0, 1'b0, "wrap");
    check_eq("wrap_addr0", 32'(addr_log[0]), 32'h7E);
    check_eq("wrap_addr1", 32'(addr_log[1]), 32'h7F);
    check_eq("wrap_addr2", 32'(addr_log[2]), 32'h00);
    check_eq("wrap_addr3", 32'(addr_log[3]), 32'h01);

    // LEN=16 with READY toggling
    start_cmd(7'h30, 8'd16);
    run_stream(7'h30, 16, 1, 1'b0, "toggle");

    // LEN=0: DONE pulse only
    start_cmd(7'h55, 8'd0);
    @(negedge clk);
    START = 1'b0;
    check_eq("len0_done", 32'(DONE), 32'd1);
    check_eq("len0_busy", 32'(BUSY), 32'd0);
    check_eq("len0_valid", 32'(VALID), 32'd0);
    @(negedge clk);
    check_eq("len0_done_clr", 32'(DONE), 32'd0);
    check_eq("len0_busy2", 32'(BUSY), 32'd0);
    check_eq("len0_valid2", 32'(VALID), 32'd0);

    // START during RUN is ignored
    start_cmd(7'h40, 8'd6);
    run_stream(7'h40, 6, 0, 1'b1, "ignore");
    @(negedge clk);
    check_eq("ignore_idle_valid", 32'(VALID), 32'd0);
    check_eq("ignore_idle_busy", 32'(BUSY), 32'd0);

    // LEN=128 with a 20-cycle initial stall
    start_cmd(7'h20, 8'd128);
    run_stream(7'h20, 128, 2, 1'b0, "stall");

    // Reset mid-command, then a fresh command
    READY = 1'b1;
    start_cmd(7'h08, 8'd8);
    repeat (5) begin
      @(negedge clk);
      START = 1'b0;
    end
    check_eq("mid_valid_pre", 32'(VALID), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_addr", 32'(ADDR_R), 32'd0);
    check_eq("mid_rst_valid", 32'(VALID), 32'd0);
    check_eq("mid_rst_dout", 32'(DOUT), 32'd0);
    check_eq("mid_rst_busy", 32'(BUSY), 32'd0);
    check_eq("mid_rst_done", 32'(DONE), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("post_rst_idle_valid", 32'(VALID), 32'd0);
    check_eq("post_rst_idle_busy", 32'(BUSY), 32'd0);
    start_cmd(7'h00, 8'd2);
    run_stream(7'h00, 2, 0, 1'b0, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_stream_reader.md
RAM_STREAM_READER -- requirements
Module: ram_stream_reader

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 7, RAM address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, RAM word width.
REQ-003 SHALL use one clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 START  input  1  one-cycle command strobe; sampled only in IDLE.
REQ-006 BASE  input  BUS_WIDTH  first RAM address, sampled with START.
REQ-007 LEN  input  BUS_WIDTH+1  word count, 0..2^BUS_WIDTH, sampled with START.
REQ-008 ADDR_R  output  BUS_WIDTH  registered read address to the 2-port RAM read port.
REQ-009 RAM_DOUT  input  DATA_WIDTH  RAM registered read data, valid one cycle after ADDR_R.
REQ-010 DOUT  output  DATA_WIDTH  stream data.
REQ-011 VALID  output  1  DOUT holds a word.
REQ-012 READY  input  1  sink accepts; a transfer occurs on VALID&READY at the rising edge.
REQ-013 BUSY  output  1  command in progress.
REQ-014 DONE  output  1  one-cycle pulse at command completion.

Function
REQ-015 SHALL have FSM states IDLE, RUN, DRAIN.
REQ-016 IDLE->RUN on START with LEN>0; latch BASE into the address counter and LEN into the issue and output counters.
REQ-017 START with LEN=0 in IDLE SHALL stay in IDLE, emit no data, and pulse DONE in the next cycle.
REQ-018 START outside IDLE SHALL be ignored, with no effect on any state.
REQ-019 Issue in cycle c: ADDR_R holds the address during c; RAM_DOUT is captured into the output FIFO at the end of c+1; the word is visible on VALID/DOUT from c+2.
REQ-020 A read SHALL issue when issue-remaining>0 and (FIFO occupancy + in-flight reads) < 4; in-flight tracking uses a 2-stage valid shift register.
REQ-021 Each issue SHALL post-increment the address counter modulo 2^BUS_WIDTH (wrap 2^BUS_WIDTH-1 -> 0).
REQ-022 RUN->DRAIN when the last read issues; DRAIN->IDLE after the LEN-th stream transfer.
REQ-023 DONE SHALL pulse in the cycle after the final transfer; BUSY is high from the cycle after START through the DONE cycle.
REQ-024 With READY held high, sustained throughput SHALL be 1 word/cycle; first VALID appears 3 cycles after the START edge.
REQ-025 VALID SHALL not drop, and DOUT SHALL not change, while VALID=1 and READY=0.
REQ-026 Words SHALL be delivered in address order with no loss or duplication under any READY pattern.
REQ-027 The FIFO SHALL never overflow; simultaneous push and pop at full or empty occupancy SHALL be handled correctly.
REQ-028 When ADDR_R is not issuing, it SHALL hold its last value; stale RAM_DOUT SHALL never be pushed.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, ADDR_R=0, VALID=0, DOUT=0, BUSY=0, DONE=0, an empty FIFO, and cleared counters and in-flight bits.
REQ-030 Reset asserted mid-command SHALL abort the command; after release the block idles until a new START.

Structure
REQ-031 SHALL place the FSM state encoding and the FIFO depth constant (4) in a shared package.
REQ-032 SHALL instantiate one sub-module, rd_fifo, a depth-4 synchronous FIFO with occupancy output, DATA_WIDTH wide.
REQ-033 SHALL contain no RAM; the block connects to an external 2-port RAM read port only.

Verification
REQ-034 BASE=0x10, LEN=4, READY=1, RAM[a]=a -> DOUT 0x10,0x11,0x12,0x13 on consecutive cycles, first at START+3, DONE one cycle after the last word.
REQ-035 BASE=0x7E, LEN=4 -> ADDR_R sequence 0x7E,0x7F,0x00,0x01.
REQ-036 LEN=16, READY toggling 1/0 per cycle -> all 16 words in order, DOUT stable while stalled, FIFO occupancy never above 4.
REQ-037 LEN=0 -> no VALID, DONE pulses one cycle later, BUSY stays 0; START during RUN -> ignored, count unchanged.
REQ-038 LEN=128, READY=0 for 20 cycles then 1 -> exactly 4 reads issued during the stall, then 128 words delivered in order.
REQ-039 rst_n pulsed low mid-LEN=8 -> all outputs return to reset values immediately, and a following START with BASE=0, LEN=2 completes normally.
